// File: rtl/mmm_core_if.sv
// Bus bundle for the bit-serial Montgomery multiplier: operand inputs,
// the serial A stream, the upstream shift-register controls and the result.
interface mmm_core_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic             A_bit;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic             ld_a_o;
  logic             shift_en_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] P_o;

  // Requester side: drives operands and the serial A bit, observes status.
  modport master (
    output en, start, A_bit, B, N,
    input  ld_a_o, shift_en_o, busy_o, done_o, P_o
  );

  // Multiplier side.
  modport slave (
    input  en, start, A_bit, B, N,
    output ld_a_o, shift_en_o, busy_o, done_o, P_o
  );
endinterface

// File: rtl/mmm_core.sv
// Bit-serial radix-2 Montgomery modular multiplier: P = A*B*2^-WIDTH mod N.
// A arrives LSB first from an upstream shift register that this block loads
// and advances; one iteration per CALC cycle, then one conditional subtract.
module mmm_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rstb,
  mmm_core_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    CORR,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH+1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             ld_a, shift_en;

  logic             q_bit;
  logic [WIDTH+1:0] b_ext, n_ext, sum;

  // Final reduction: S < 2N, so one unsigned subtract at WIDTH+1 bits
  // brings the result into [0, N).
  function automatic logic [WIDTH-1:0] final_reduce(
    input logic [WIDTH:0]   s,
    input logic [WIDTH-1:0] n
  );
    logic [WIDTH:0] n1;
    n1 = {1'b0, n};
    return (s >= n1) ? WIDTH'(s - n1) : WIDTH'(s);
  endfunction

  assign b_ext = {2'b00, bus.B};
  assign n_ext = {2'b00, bus.N};

  // One Montgomery iteration: add A_bit*B, then add N when needed to make
  // the sum even so the halving is exact. WIDTH+2 bits cannot overflow.
  always_comb begin
    q_bit = s_q[0] ^ (bus.A_bit & bus.B[0]);
    sum   = s_q + (bus.A_bit ? b_ext : '0) + (q_bit ? n_ext : '0);
  end

  // Next-state and control decode; nothing advances while en is low.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    ld_a     = 1'b0;
    shift_en = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = LOAD;
        end
        LOAD: begin
          // Upstream loads A now, so A[0] is on A_bit in the first CALC cycle.
          ld_a     = 1'b1;
          shift_en = 1'b1;
          s_d      = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
        CALC: begin
          shift_en = 1'b1;
          s_d      = sum >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_IT) state_d = CORR;
        end
        CORR: begin
          p_d     = final_reduce(s_q[WIDTH:0], bus.N);
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, accumulator, counter and result registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign bus.ld_a_o     = ld_a;
  assign bus.shift_en_o = shift_en;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = (state_q == DONE);
  assign bus.P_o        = p_q;

endmodule
